// File: rtl/bytewrite_ram_2p_lat.sv
// Dual-port byte-write RAM with req/gnt/rvalid handshakes and a fixed read latency.
// Port A reads only, port B reads/writes. Define BYTEWRITE_RAM_RANDOM_STALL_EN for LFSR-driven grant stalls.
module bytewrite_ram_2p_lat #(
  parameter              MEM_INIT_FILE = "",
  parameter int          INIT_FILE_BIN = 1,
  parameter int          SIZE          = 4096,
  parameter int          ADDR_WIDTH    = 32,
  parameter int          NB_COL        = 4,
  parameter int          COL_WIDTH     = 8,
  parameter int          READ_LATENCY  = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_req,
  output logic                          a_gnt,
  input  logic [ADDR_WIDTH-1:0]         a_addr,
  output logic                          a_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   a_rdata,
  output logic                          a_err,
  input  logic                          b_req,
  output logic                          b_gnt,
  input  logic                          b_we,
  input  logic [NB_COL-1:0]             b_be,
  input  logic [ADDR_WIDTH-1:0]         b_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   b_wdata,
  output logic                          b_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   b_rdata,
  output logic                          b_err
);

  localparam int DW = NB_COL * COL_WIDTH;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] SIZE_W = ADDR_WIDTH'(SIZE);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_check
    $fatal(1, "bytewrite_ram_2p_lat: READ_LATENCY must be in 1..4");
  end

  logic [DW-1:0] mem [SIZE];

`ifdef BYTEWRITE_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_a, lfsr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_a <= LFSR_SEED;
      lfsr_b <= LFSR_SEED ^ 16'hFFFF;
    end else begin
      lfsr_a <= {lfsr_a[14:0], lfsr_a[15] ^ lfsr_a[13] ^ lfsr_a[12] ^ lfsr_a[10]};
      lfsr_b <= {lfsr_b[14:0], lfsr_b[15] ^ lfsr_b[13] ^ lfsr_b[12] ^ lfsr_b[10]};
    end
  end

  assign a_gnt = ~rst & (lfsr_a[1:0] != 2'b00);
  assign b_gnt = ~rst & (lfsr_b[1:0] != 2'b00);
`else
  assign a_gnt = ~rst;
  assign b_gnt = ~rst;
`endif

  logic          a_acc, b_acc, a_bad, b_bad;
  logic [IW-1:0] a_idx, b_idx;

  assign a_acc = a_req & a_gnt;
  assign b_acc = b_req & b_gnt;
  // Misaligned or beyond the array: accepted but answered with an error and no access.
  assign a_bad = (a_addr[1:0] != 2'b00) || ({2'b00, a_addr[ADDR_WIDTH-1:2]} >= SIZE_W);
  assign b_bad = (b_addr[1:0] != 2'b00) || ({2'b00, b_addr[ADDR_WIDTH-1:2]} >= SIZE_W);
  assign a_idx = a_addr[IW+1:2];
  assign b_idx = b_addr[IW+1:2];

  always_ff @(posedge clk) begin
    if (b_acc && !b_bad && b_we) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (b_be[i]) mem[b_idx][i*COL_WIDTH +: COL_WIDTH] <= b_wdata[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  logic [READ_LATENCY-1:0] a_pv, a_pe, b_pv, b_pe;
  logic [DW-1:0]           a_pd [READ_LATENCY];
  logic [DW-1:0]           b_pd [READ_LATENCY];

  // Stage 0 reads the array at the accept edge, so both ports see pre-write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pv <= '0;
      a_pe <= '0;
      b_pv <= '0;
      b_pe <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        a_pd[s] <= '0;
        b_pd[s] <= '0;
      end
    end else begin
      a_pv[0] <= a_acc;
      a_pe[0] <= a_acc & a_bad;
      a_pd[0] <= (a_acc && !a_bad) ? mem[a_idx] : '0;
      b_pv[0] <= b_acc;
      b_pe[0] <= b_acc & b_bad;
      b_pd[0] <= (b_acc && !b_bad) ? mem[b_idx] : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        a_pv[s] <= a_pv[s-1];
        a_pe[s] <= a_pe[s-1];
        a_pd[s] <= a_pd[s-1];
        b_pv[s] <= b_pv[s-1];
        b_pe[s] <= b_pe[s-1];
        b_pd[s] <= b_pd[s-1];
      end
    end
  end

  assign a_rvalid = a_pv[READ_LATENCY-1] & ~rst;
  assign a_err    = a_pe[READ_LATENCY-1] & ~rst;
  assign a_rdata  = rst ? '0 : a_pd[READ_LATENCY-1];
  assign b_rvalid = b_pv[READ_LATENCY-1] & ~rst;
  assign b_err    = b_pe[READ_LATENCY-1] & ~rst;
  assign b_rdata  = rst ? '0 : b_pd[READ_LATENCY-1];

endmodule

// File: tb/tb_bytewrite_ram_2p_lat.sv
// Bench for bytewrite_ram_2p_lat: directed scenarios followed by random traffic,
// compared cycle by cycle against a word-array model with per-port response queues.
module tb_bytewrite_ram_2p_lat;
  localparam int LAT  = 3;
  localparam int SIZE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_rdata;
  logic        b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;

  always #5 clk = ~clk;

  bytewrite_ram_2p_lat #(
    .SIZE(SIZE),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_gnt(a_gnt), .a_addr(a_addr),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_be(b_be),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic        err;
    logic        known;
    logic [31:0] data;
  } rsp_t;

  rsp_t        qa[$];
  rsp_t        qb[$];
  logic [31:0] ref_mem [SIZE];
  bit          known [SIZE];
  int          edge_n = 0;

  function automatic bit bad(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= SIZE);
  endfunction

  task automatic check_port(input string p, input logic rv, input logic er, input logic [31:0] rd,
                            inout rsp_t q[$]);
    rsp_t r;
    if (q.size() > 0 && q[0].due == edge_n) begin
      r = q.pop_front();
      chk_eq({p, "_rvalid"}, rv, 1'b1);
      chk_eq({p, "_err"}, er, r.err);
      if (r.known) chk_eq({p, "_rdata"}, rd, r.data);
    end else begin
      chk_eq({p, "_rvalid_idle"}, rv, 1'b0);
      if (rst) begin
        chk_eq({p, "_err_rst"}, er, 1'b0);
        chk_eq({p, "_rdata_rst"}, rd, 32'h0);
      end
    end
  endtask

  // Model the coming edge from the driven inputs, let it happen, then check at the falling edge.
  task automatic step();
    rsp_t r;
    int   w;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_req) begin
        r.due   = edge_n + LAT;
        r.err   = bad(a_addr);
        w       = r.err ? 0 : int'(a_addr / 4);
        r.known = r.err || known[w];
        r.data  = r.err ? 32'h0 : ref_mem[w];
        qa.push_back(r);
      end
      if (b_req) begin
        r.due   = edge_n + LAT;
        r.err   = bad(b_addr);
        w       = r.err ? 0 : int'(b_addr / 4);
        r.known = r.err || known[w];
        r.data  = r.err ? 32'h0 : ref_mem[w];
        qb.push_back(r);
        if (!r.err && b_we) begin
          for (int i = 0; i < 4; i++)
            if (b_be[i]) ref_mem[w][8*i +: 8] = b_wdata[8*i +: 8];
          if (b_be == 4'hF) known[w] = 1'b1;
        end
      end
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    chk_eq("a_gnt", a_gnt, !rst);
    chk_eq("b_gnt", b_gnt, !rst);
    check_port("a", a_rvalid, a_err, a_rdata, qa);
    check_port("b", b_rvalid, b_err, b_rdata, qb);
  endtask

  task automatic drive(input logic ar, input logic [31:0] aa, input logic br, input logic bw,
                       input logic [3:0] be, input logic [31:0] ba, input logic [31:0] bd);
    a_req = ar; a_addr = aa;
    b_req = br; b_we = bw; b_be = be; b_addr = ba; b_wdata = bd;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] x;
    x = 32'($urandom_range(0, SIZE + 1)) * 4;
    if ($urandom_range(0, 7) == 0) x = x + 32'($urandom_range(1, 3));
    return x;
  endfunction

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
    idle(2);
    rst = 1'b0;

    for (int w = 0; w < SIZE; w++) begin
      logic [31:0] d;
      d = $urandom;
      if (w == 0) d = 32'h00000013;
      if (w == 4) d = 32'h11223344;
      if (w == 8) d = 32'h0;
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(w * 4), d);
    end
    idle(LAT);

    drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h10, 32'hAABBCCDD);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    idle(LAT);

    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
    idle(LAT);

    drive(1'b1, 32'h20, 1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
    drive(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(LAT);

    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2, 32'h0);
    drive(1'b1, 32'(SIZE * 4), 1'b1, 1'b1, 4'hF, 32'h6, 32'h12345678);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
    idle(LAT);

    drive(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(LAT);
    drive(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    idle(LAT);

    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      a_req   = ($urandom_range(0, 3) != 0);
      a_addr  = rand_addr();
      b_req   = ($urandom_range(0, 3) != 0);
      b_we    = $urandom_range(0, 1) != 0;
      b_be    = 4'($urandom_range(0, 15));
      b_addr  = rand_addr();
      b_wdata = $urandom;
      step();
    end
    rst = 1'b0;
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
